// File: rtl/tbird_pkg.sv
// Shared definitions for the T-bird tail-light sequencer: state encoding and lamp patterns.
package tbird_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        L1    = 4'd1,
        L2    = 4'd2,
        L3    = 4'd3,
        L4    = 4'd4,
        R1    = 4'd5,
        R2    = 4'd6,
        R3    = 4'd7,
        R4    = 4'd8,
        H_ON  = 4'd9,
        H_OFF = 4'd10
    } state_t;

    // Index k holds the nibble for step Lk / Rk; lamps grow outward from the centre.
    localparam logic [4:1][3:0] LEFT_PAT  = {4'b1111, 4'b0111, 4'b0011, 4'b0001};
    localparam logic [4:1][3:0] RIGHT_PAT = {4'b1111, 4'b1110, 4'b1100, 4'b1000};

    localparam logic [7:0] LAMP_ALL = 8'hFF;
    localparam logic [7:0] LAMP_OFF = 8'h00;

endpackage

// File: rtl/tbird_prescaler.sv
// Lamp-step prescaler: counts 0..TICK_DIV-1 while enabled and flags the last count.
module tbird_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    input  logic CLR,
    output logic TICK
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // A disabled prescaler sits at zero so a fresh request always sees full latency.
    always_ff @(posedge CLK) begin
        if (RST || CLR || !EN) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign TICK = EN && (cnt == LAST);

endmodule

// File: rtl/tbird_turn_ctrl.sv
// T-bird tail-light sequencer: arbitrates hazard/turn/brake requests and drives the 8-lamp bus.
module tbird_turn_ctrl
    import tbird_pkg::*;
#(
    parameter int TICK_DIV = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       LEFT_REQ,
    input  logic       RIGHT_REQ,
    input  logic       HAZ_REQ,
    input  logic       BRAKE,
    output logic [7:0] TLIGHT,
    output logic       BUSY,
    output logic       TICK
);

    state_t state;
    state_t next_state;
    logic   haz;
    logic   presc_en;
    logic   presc_clr;

    assign haz      = HAZ_REQ | (LEFT_REQ & RIGHT_REQ);
    assign presc_en = (state != IDLE) | LEFT_REQ | RIGHT_REQ | HAZ_REQ;

    tbird_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .CLK (CLK),
        .RST (RST),
        .EN  (presc_en),
        .CLR (presc_clr),
        .TICK(TICK)
    );

    // Side not running a turn pattern shows the brake overlay; hazard states ignore the brake.
    function automatic logic [7:0] decode(input state_t s, input logic brk);
        logic [3:0] side;
        side = brk ? 4'b1111 : 4'b0000;
        case (s)
            L1:      decode = {LEFT_PAT[1], side};
            L2:      decode = {LEFT_PAT[2], side};
            L3:      decode = {LEFT_PAT[3], side};
            L4:      decode = {LEFT_PAT[4], side};
            R1:      decode = {side, RIGHT_PAT[1]};
            R2:      decode = {side, RIGHT_PAT[2]};
            R3:      decode = {side, RIGHT_PAT[3]};
            R4:      decode = {side, RIGHT_PAT[4]};
            H_ON:    decode = LAMP_ALL;
            H_OFF:   decode = LAMP_OFF;
            default: decode = {side, side};
        endcase
    endfunction

    always_comb begin
        next_state = state;
        presc_clr  = 1'b0;
        // Hazard preempts immediately and restarts the step timing from zero.
        if (haz && (state != H_ON) && (state != H_OFF)) begin
            next_state = H_ON;
            presc_clr  = 1'b1;
        end else if (TICK) begin
            case (state)
                IDLE: begin
                    if (LEFT_REQ)       next_state = L1;
                    else if (RIGHT_REQ) next_state = R1;
                end
                L1:      next_state = LEFT_REQ  ? L2 : IDLE;
                L2:      next_state = LEFT_REQ  ? L3 : IDLE;
                L3:      next_state = LEFT_REQ  ? L4 : IDLE;
                L4:      next_state = IDLE;
                R1:      next_state = RIGHT_REQ ? R2 : IDLE;
                R2:      next_state = RIGHT_REQ ? R3 : IDLE;
                R3:      next_state = RIGHT_REQ ? R4 : IDLE;
                R4:      next_state = IDLE;
                H_ON:    next_state = H_OFF;
                H_OFF:   next_state = haz ? H_ON : IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            TLIGHT <= LAMP_OFF;
            BUSY   <= 1'b0;
        end else begin
            state  <= next_state;
            TLIGHT <= decode(next_state, BRAKE);
            BUSY   <= (next_state != IDLE);
        end
    end

endmodule

// File: tb/tb_tbird_turn_ctrl.sv
// Directed bench for tbird_turn_ctrl: vector table for TICK_DIV=4 plus hand sequences.
module tb_tbird_turn_ctrl;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       rst = 1'b1, left = 1'b0, right = 1'b0, haz = 1'b0, brake = 1'b0;
    logic [7:0] tlight;
    logic       busy, tick;

    logic       rst1 = 1'b1, left1 = 1'b0;
    logic [7:0] tlight1;
    logic       busy1, tick1;

    tbird_turn_ctrl #(.TICK_DIV(4)) dut (
        .CLK(CLK), .RST(rst), .LEFT_REQ(left), .RIGHT_REQ(right), .HAZ_REQ(haz),
        .BRAKE(brake), .TLIGHT(tlight), .BUSY(busy), .TICK(tick)
    );

    tbird_turn_ctrl #(.TICK_DIV(1)) dut1 (
        .CLK(CLK), .RST(rst1), .LEFT_REQ(left1), .RIGHT_REQ(1'b0), .HAZ_REQ(1'b0),
        .BRAKE(1'b0), .TLIGHT(tlight1), .BUSY(busy1), .TICK(tick1)
    );

    typedef struct {
        logic       r, l, rr, h, b;
        int         n;
        logic [7:0] tl;
        logic       bz;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   passes = 0;

    task automatic add(input logic r, l, rr, h, b, input int n, input logic [7:0] tl, input logic bz);
        vec_t v;
        v.r = r; v.l = l; v.rr = rr; v.h = h; v.b = b; v.n = n; v.tl = tl; v.bz = bz;
        vecs.push_back(v);
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %b required %b", name, act, exp);
    endtask

    logic [7:0] exp6 [6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held with every request active, then hazard right after release.
        add(1,1,1,1,1, 1, 8'h00, 0);
        add(1,1,1,1,1, 1, 8'h00, 0);
        add(1,1,1,1,1, 1, 8'h00, 0);
        add(0,1,1,1,1, 1, 8'hFF, 1);
        // Left sequence with wrap, exact step timing.
        add(1,0,0,0,0, 1, 8'h00, 0);
        add(0,1,0,0,0, 3, 8'h00, 0);
        add(0,1,0,0,0, 1, 8'h10, 1);
        add(0,1,0,0,0, 3, 8'h10, 1);
        add(0,1,0,0,0, 1, 8'h30, 1);
        add(0,1,0,0,0, 3, 8'h30, 1);
        add(0,1,0,0,0, 1, 8'h70, 1);
        add(0,1,0,0,0, 3, 8'h70, 1);
        add(0,1,0,0,0, 1, 8'hF0, 1);
        add(0,1,0,0,0, 3, 8'hF0, 1);
        add(0,1,0,0,0, 1, 8'h00, 0);
        add(0,1,0,0,0, 3, 8'h00, 0);
        add(0,1,0,0,0, 1, 8'h10, 1);
        // Right sequence.
        add(1,0,0,0,0, 1, 8'h00, 0);
        add(0,0,1,0,0, 3, 8'h00, 0);
        add(0,0,1,0,0, 1, 8'h08, 1);
        add(0,0,1,0,0, 3, 8'h08, 1);
        add(0,0,1,0,0, 1, 8'h0C, 1);
        add(0,0,1,0,0, 4, 8'h0E, 1);
        add(0,0,1,0,0, 4, 8'h0F, 1);
        add(0,0,1,0,0, 4, 8'h00, 0);
        // Left abandoned in L2; prescaler must restart from zero afterwards.
        add(1,0,0,0,0, 1, 8'h00, 0);
        add(0,1,0,0,0, 4, 8'h10, 1);
        add(0,1,0,0,0, 4, 8'h30, 1);
        add(0,0,0,0,0, 3, 8'h30, 1);
        add(0,0,0,0,0, 1, 8'h00, 0);
        add(0,0,0,0,0, 5, 8'h00, 0);
        add(0,1,0,0,0, 3, 8'h00, 0);
        add(0,1,0,0,0, 1, 8'h10, 1);
        // Hazard preempting L2, flashing, then released.
        add(1,0,0,0,0, 1, 8'h00, 0);
        add(0,1,0,0,0, 4, 8'h10, 1);
        add(0,1,0,0,0, 4, 8'h30, 1);
        add(0,1,0,1,0, 1, 8'hFF, 1);
        add(0,0,0,1,0, 3, 8'hFF, 1);
        add(0,0,0,1,0, 1, 8'h00, 1);
        add(0,0,0,1,0, 3, 8'h00, 1);
        add(0,0,0,1,0, 1, 8'hFF, 1);
        add(0,0,0,1,0, 4, 8'h00, 1);
        add(0,0,0,0,0, 3, 8'h00, 1);
        add(0,0,0,0,0, 1, 8'h00, 0);
        // Brake overlay in IDLE and L states; both turns together give hazard.
        add(1,0,0,0,0, 1, 8'h00, 0);
        add(0,0,0,0,1, 1, 8'hFF, 0);
        add(0,0,0,0,0, 1, 8'h00, 0);
        add(0,1,0,0,1, 3, 8'hFF, 0);
        add(0,1,0,0,1, 1, 8'h1F, 1);
        add(0,1,0,0,1, 4, 8'h3F, 1);
        add(0,1,0,0,0, 1, 8'h30, 1);
        add(0,1,1,0,1, 1, 8'hFF, 1);
        add(0,1,1,0,1, 3, 8'hFF, 1);
        add(0,1,1,0,1, 1, 8'h00, 1);

        @(posedge CLK); #1;
        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].r; left = vecs[i].l; right = vecs[i].rr;
            haz = vecs[i].h; brake = vecs[i].b;
            repeat (vecs[i].n) @(posedge CLK);
            #1;
            check8($sformatf("vec%0d tlight", i), tlight, vecs[i].tl);
            check1($sformatf("vec%0d busy", i), busy, vecs[i].bz);
        end

        // TICK timing on the TICK_DIV=4 instance.
        rst = 1; left = 0; right = 0; haz = 0; brake = 0;
        @(posedge CLK); #1;
        check1("idle tick", tick, 1'b0);
        rst = 0; left = 1;
        repeat (3) @(posedge CLK);
        #1;
        check1("tick at count 3", tick, 1'b1);
        check8("tlight before step", tlight, 8'h00);
        @(posedge CLK); #1;
        check8("tlight first step", tlight, 8'h10);
        check1("tick after step", tick, 1'b0);
        left = 0;

        // TICK_DIV=1: one lamp step per edge.
        exp6[0] = 8'h10; exp6[1] = 8'h30; exp6[2] = 8'h70;
        exp6[3] = 8'hF0; exp6[4] = 8'h00; exp6[5] = 8'h10;
        rst1 = 1;
        @(posedge CLK); #1;
        rst1 = 0;
        @(posedge CLK); #1;
        check1("div1 idle tick", tick1, 1'b0);
        check8("div1 idle tlight", tlight1, 8'h00);
        left1 = 1; #1;
        check1("div1 tick on request", tick1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            @(posedge CLK); #1;
            check8($sformatf("div1 step%0d tlight", k), tlight1, exp6[k]);
            check1($sformatf("div1 step%0d tick", k), tick1, 1'b1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
